// File: rtl/bus_mem_slave.sv
// -----------------------------------------------------------------------------
// bus_mem_slave
//
// Word-addressed memory responder at the end of the shared hart bus. It takes
// one request at a time and answers with a single-cycle acknowledge LATENCY
// cycles after capture. It supports byte-enabled plain reads/writes and RV32A
// atomics: LR/SC with one reservation per hart, and AMO read-modify-write.
//
// Parameters
//   ADDR_WIDTH  word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//   LATENCY     cycles from request capture to o_ack (1..15)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_bus_en     request valid, held by the initiator until o_ack
//   i_wr_en      1 = write, 0 = read (ignored for atomics)
//   i_wr_data    store data / AMO operand
//   i_addr       byte address; word index = i_addr[ADDR_WIDTH+1:2]
//   i_byte_en    byte lanes for plain writes
//   i_id         requesting hart (0/1)
//   i_atomic     request is an RV32A operation
//   i_operation  AMO funct7; funct5 = [6:2], aq/rl ignored
//   o_ack        one-cycle completion pulse
//   o_rd_data    response data, zero outside the ack cycle
// -----------------------------------------------------------------------------
module bus_mem_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_byte_en,
  input  logic        i_id,
  input  logic        i_atomic,
  input  logic [6:0]  i_operation,
  output logic        o_ack,
  output logic [31:0] o_rd_data
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_CNT = 4'(LATENCY - 1);

  // RV32A funct5 encodings
  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       capture;

  // Captured request
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [31:0]           cap_data;
  logic [3:0]            cap_be;
  logic                  cap_id;
  logic                  cap_atomic;
  logic                  cap_wr;
  logic [4:0]            cap_f5;

  // Storage and the word read at capture time
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;

  // Per-hart reservations
  logic [1:0]            res_valid;
  logic [ADDR_WIDTH-1:0] res_idx [2];

  // Response / commit decode
  logic [31:0] resp;
  logic [31:0] wr_word;
  logic [3:0]  wr_mask;
  logic        wr_do;
  logic        commit;
  logic        lr_set;
  logic        sc_clear;
  logic        sc_ok;

  // Address bits above the memory depth alias; aq/rl carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0], i_operation[1:0]};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_bus_en) begin
          capture   = 1'b1;
          state_nxt = (LATENCY == 1) ? ACK : WAIT;
          cnt_nxt   = (LATENCY == 1) ? 4'd0 : WAIT_CNT;
        end
      end
      WAIT: begin
        // A counter at or below 1 means the latency has elapsed.
        if (cnt <= 4'd1) begin
          state_nxt = ACK;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK:     state_nxt = IDLE;  // i_bus_en deliberately not sampled here
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_idx    <= '0;
      cap_data   <= '0;
      cap_be     <= '0;
      cap_id     <= 1'b0;
      cap_atomic <= 1'b0;
      cap_wr     <= 1'b0;
      cap_f5     <= '0;
    end else if (capture) begin
      cap_idx    <= i_addr[ADDR_WIDTH+1:2];
      cap_data   <= i_wr_data;
      cap_be     <= i_byte_en;
      cap_id     <= i_id;
      cap_atomic <= i_atomic;
      cap_wr     <= i_wr_en;
      cap_f5     <= i_operation[6:2];
    end
  end

  // ---------------------------------------------------------------------------
  // Response and write-back decode (used only in ACK)
  // ---------------------------------------------------------------------------
  assign sc_ok = res_valid[cap_id] && (res_idx[cap_id] == cap_idx);

  always_comb begin
    resp     = '0;
    wr_word  = rd_word;
    wr_mask  = 4'h0;
    wr_do    = 1'b0;
    lr_set   = 1'b0;
    sc_clear = 1'b0;
    if (!cap_atomic) begin
      if (cap_wr) begin
        wr_do   = 1'b1;
        wr_word = cap_data;
        wr_mask = cap_be;
      end else begin
        resp = rd_word;
      end
    end else begin
      wr_mask = 4'hF;
      resp    = rd_word;  // AMOs, LR and unknown ops all return the old word
      case (cap_f5)
        F5_LR: lr_set = 1'b1;
        F5_SC: begin
          sc_clear = 1'b1;
          if (sc_ok) begin
            wr_do   = 1'b1;
            wr_word = cap_data;
            resp    = 32'd0;
          end else begin
            resp = 32'd1;
          end
        end
        F5_SWAP: begin wr_do = 1'b1; wr_word = cap_data;            end
        F5_ADD:  begin wr_do = 1'b1; wr_word = rd_word + cap_data;  end
        F5_XOR:  begin wr_do = 1'b1; wr_word = rd_word ^ cap_data;  end
        F5_AND:  begin wr_do = 1'b1; wr_word = rd_word & cap_data;  end
        F5_OR:   begin wr_do = 1'b1; wr_word = rd_word | cap_data;  end
        F5_MIN: begin
          wr_do   = 1'b1;
          wr_word = ($signed(rd_word) < $signed(cap_data)) ? rd_word : cap_data;
        end
        F5_MAX: begin
          wr_do   = 1'b1;
          wr_word = ($signed(rd_word) > $signed(cap_data)) ? rd_word : cap_data;
        end
        F5_MINU: begin
          wr_do   = 1'b1;
          wr_word = (rd_word < cap_data) ? rd_word : cap_data;
        end
        F5_MAXU: begin
          wr_do   = 1'b1;
          wr_word = (rd_word > cap_data) ? rd_word : cap_data;
        end
        default: ;  // unknown funct5: plain read, no reservation
      endcase
    end
  end

  assign commit    = (state == ACK) && wr_do;
  assign o_ack     = (state == ACK);
  assign o_rd_data = o_ack ? resp : 32'd0;

  // ---------------------------------------------------------------------------
  // Memory array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; this keeps it mappable to block RAM.
  // A reset mid-transaction forces state to IDLE, which deasserts commit.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      rd_word <= mem[i_addr[ADDR_WIDTH+1:2]];
    end
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[k]) begin
          mem[cap_idx][8*k +: 8] <= wr_word[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reservations
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      res_valid <= '0;
      res_idx   <= '{default: '0};
    end else if (state == ACK) begin
      // Any committed write to a reserved word kills that reservation.
      for (int h = 0; h < 2; h++) begin
        if (commit && res_valid[h] && (res_idx[h] == cap_idx)) begin
          res_valid[h] <= 1'b0;
        end
      end
      if (sc_clear) begin
        res_valid[cap_id] <= 1'b0;
      end
      if (lr_set) begin
        res_valid[cap_id] <= 1'b1;
        res_idx[cap_id]   <= cap_idx;
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_slave
//
// Self-checking bench for bus_mem_slave (ADDR_WIDTH=10, LATENCY=2). Directed
// scenarios cover reset, byte enables, LR/SC, reservation kill, AMO boundary
// values and reset mid-transaction; a randomized phase mixes plain and atomic
// traffic from both harts against a reference model built from a word map and
// two reservation records.
// -----------------------------------------------------------------------------
module tb_bus_mem_slave;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic        id;
  logic        atomic;
  logic [6:0]  operation;
  logic        ack;
  logic [31:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] ref_mem [int];
  bit          ref_rv  [2];
  int          ref_ri  [2];

  bus_mem_slave #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bus_en    (bus_en),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .i_addr      (addr),
    .i_byte_en   (byte_en),
    .i_id        (id),
    .i_atomic    (atomic),
    .i_operation (operation),
    .o_ack       (ack),
    .o_rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: applies one transaction to the word map and returns the
  // response the bus should see.
  task automatic model(input logic wr, input logic [31:0] data, input logic [31:0] a,
                       input logic [3:0] be, input logic hid, input logic at,
                       input logic [4:0] f5, output logic [31:0] ret);
    int          idx;
    logic [31:0] old, nw;
    bit          do_wr;
    idx   = int'(a[AW+1:2]);
    old   = ref_mem.exists(idx) ? ref_mem[idx] : 32'hx;
    nw    = old;
    do_wr = 0;
    ret   = old;
    if (!at) begin
      if (wr) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) nw[8*k +: 8] = data[8*k +: 8];
        do_wr = 1;
        ret   = 0;
      end
    end else begin
      case (f5)
        5'b00010: begin ref_rv[hid] = 1; ref_ri[hid] = idx; end
        5'b00011: begin
          if (ref_rv[hid] && ref_ri[hid] == idx) begin
            nw = data; do_wr = 1; ret = 0;
          end else begin
            ret = 1;
          end
          ref_rv[hid] = 0;
        end
        5'b00001: begin nw = data;       do_wr = 1; end
        5'b00000: begin nw = old + data; do_wr = 1; end
        5'b00100: begin nw = old ^ data; do_wr = 1; end
        5'b01100: begin nw = old & data; do_wr = 1; end
        5'b01000: begin nw = old | data; do_wr = 1; end
        5'b10000: begin nw = ($signed(old) < $signed(data)) ? old : data; do_wr = 1; end
        5'b10100: begin nw = ($signed(old) > $signed(data)) ? old : data; do_wr = 1; end
        5'b11000: begin nw = (old < data) ? old : data; do_wr = 1; end
        5'b11100: begin nw = (old > data) ? old : data; do_wr = 1; end
        default: ;
      endcase
    end
    if (do_wr) begin
      ref_mem[idx] = nw;
      for (int h = 0; h < 2; h++)
        if (ref_rv[h] && ref_ri[h] == idx) ref_rv[h] = 0;
    end
  endtask

  // One bus transaction, started at a falling edge. mode: 0 = drop bus_en in
  // the ack cycle, 1 = hold bus_en through ACK, 2 = drop right after capture.
  task automatic bus_txn(input logic wr, input logic [31:0] data, input logic [31:0] a,
                         input logic [3:0] be, input logic hid, input logic at,
                         input logic [4:0] f5, input int mode, input string tag,
                         output logic [31:0] got);
    logic [31:0] exp;
    int          lat;
    bit          seen;
    logic [1:0]  aqrl;
    aqrl      = 2'($urandom_range(0, 3));
    wr_en     = wr;
    wr_data   = data;
    addr      = a;
    byte_en   = be;
    id        = hid;
    atomic    = at;
    operation = {f5, aqrl};
    bus_en    = 1'b1;
    @(posedge clk);
    if (mode == 2) begin
      #1 bus_en = 1'b0;
    end
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack) seen = 1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    got = rd_data;
    model(wr, data, a, be, hid, at, f5, exp);
    check(tag, got, exp);
    if (mode != 1) bus_en = 1'b0;
    @(negedge clk);
    bus_en = 1'b0;
    check({tag, "_pulse"}, {31'd0, ack}, 32'd0);
    check({tag, "_rdz"}, rd_data, 32'd0);
    @(negedge clk);
    check({tag, "_nodup"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic hid);
    logic [31:0] g;
    bus_txn(1'b1, d, a, 4'hF, hid, 1'b0, 5'd0, 0, "wr", g);
  endtask

  task automatic rd_word(input logic [31:0] a, input string tag, output logic [31:0] g);
    bus_txn(1'b0, $urandom(), a, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 5'd0, 0, tag, g);
  endtask

  task automatic amo(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                     input logic hid, input string tag, output logic [31:0] g);
    bus_txn(1'b0, d, a, 4'($urandom_range(0, 15)), hid, 1'b1, f5, 0, tag, g);
  endtask

  logic [4:0] amo_ops [9] = '{5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
                              5'b10000, 5'b10100, 5'b11000, 5'b11100};
  logic [4:0] bad_ops [3] = '{5'b00110, 5'b11111, 5'b00101};

  initial begin
    logic [31:0] g;
    rst       = 1'b1;
    bus_en    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    addr      = '0;
    byte_en   = '0;
    id        = 1'b0;
    atomic    = 1'b0;
    operation = '0;
    ref_rv    = '{0, 0};
    ref_ri    = '{0, 0};

    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rd", rd_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ack", {31'd0, ack}, 32'd0);

    // Basic write/read, latency and write-ack data
    bus_txn(1'b1, 32'hDEADBEEF, 32'h10, 4'hF, 1'b0, 1'b0, 5'd0, 0, "wr_dead", g);
    check("wr_ack_data", g, 32'd0);
    rd_word(32'h10, "rd_dead", g);
    check("rd_dead_lit", g, 32'hDEADBEEF);
    // Alias above the memory depth
    rd_word(32'h10 | 32'h0000_5000, "rd_alias", g);
    check("rd_alias_lit", g, 32'hDEADBEEF);

    // Byte enables
    wr_word(32'h0, 32'h0, 1'b0);
    bus_txn(1'b1, 32'hAABBCCDD, 32'h0, 4'b0101, 1'b1, 1'b0, 5'd0, 0, "wr_be", g);
    rd_word(32'h0, "rd_be", g);
    check("rd_be_lit", g, 32'h00BB00DD);

    // LR / SC
    wr_word(32'h20, 32'h0, 1'b0);
    amo(5'b00010, 32'h20, 32'h0, 1'b0, "lr0", g);
    amo(5'b00011, 32'h20, 32'd5, 1'b0, "sc_ok", g);
    check("sc_ok_lit", g, 32'd0);
    rd_word(32'h20, "rd_sc", g);
    check("rd_sc_lit", g, 32'd5);
    amo(5'b00011, 32'h20, 32'd6, 1'b0, "sc_again", g);
    check("sc_again_lit", g, 32'd1);
    rd_word(32'h20, "rd_sc2", g);
    check("rd_sc2_lit", g, 32'd5);

    // Reservation kill by another hart's plain write
    amo(5'b00010, 32'h20, 32'h0, 1'b0, "lr_k", g);
    wr_word(32'h20, 32'd7, 1'b1);
    amo(5'b00011, 32'h20, 32'd9, 1'b0, "sc_kill", g);
    check("sc_kill_lit", g, 32'd1);
    rd_word(32'h20, "rd_kill", g);
    check("rd_kill_lit", g, 32'd7);

    // AMO boundaries
    wr_word(32'h40, 32'hFFFFFFFE, 1'b0);
    amo(5'b10100, 32'h40, 32'd1, 1'b1, "amomax", g);
    check("amomax_lit", g, 32'hFFFFFFFE);
    rd_word(32'h40, "rd_max", g);
    check("rd_max_lit", g, 32'd1);
    amo(5'b11000, 32'h40, 32'h80000000, 1'b0, "amominu", g);
    check("amominu_lit", g, 32'd1);
    amo(5'b00000, 32'h40, 32'hFFFFFFFF, 1'b1, "amoadd", g);
    rd_word(32'h40, "rd_add", g);
    check("rd_add_lit", g, 32'd0);

    // Reset in WAIT during a write: no ack, write dropped, reservations gone
    wr_word(32'h30, 32'h11, 1'b0);
    amo(5'b00010, 32'h30, 32'h0, 1'b1, "lr_pre_rst", g);
    wr_en   = 1'b1;
    wr_data = 32'h55;
    addr    = 32'h30;
    byte_en = 4'hF;
    id      = 1'b0;
    atomic  = 1'b0;
    bus_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_ack", {31'd0, ack}, 32'd0);
    check("rst_mid_rd", rd_data, 32'd0);
    @(negedge clk);
    check("rst_mid_ack2", {31'd0, ack}, 32'd0);
    rst    = 1'b0;
    bus_en = 1'b0;
    ref_rv = '{0, 0};
    @(negedge clk);
    check("rst_no_late_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    rd_word(32'h30, "rd_after_rst", g);
    check("rd_after_rst_lit", g, 32'h11);
    amo(5'b00011, 32'h30, 32'h77, 1'b1, "sc_after_rst", g);
    check("sc_after_rst_lit", g, 32'd1);

    // Randomized mixed traffic on a small word set
    for (int w = 0; w < 8; w++) wr_word(32'(w) << 2, $urandom(), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [31:0] a, d, r;
      logic        hid;
      kind = $urandom_range(0, 9);
      r    = $urandom();
      a    = (r & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      d    = $urandom();
      if ($urandom_range(0, 3) == 0) d = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom_range(0, 3))};
      hid  = 1'($urandom_range(0, 1));
      case (kind)
        0, 1, 2: bus_txn(1'($urandom_range(0, 1)), d, a, 4'($urandom_range(0, 15)), hid,
                         1'b0, 5'd0, $urandom_range(0, 2), "rnd_plain", g);
        3:       bus_txn(1'b0, d, a, 4'hF, hid, 1'b1, 5'b00010, $urandom_range(0, 2), "rnd_lr", g);
        4:       bus_txn(1'b0, d, a, 4'hF, hid, 1'b1, 5'b00011, $urandom_range(0, 2), "rnd_sc", g);
        9:       bus_txn(1'b1, d, a, 4'hF, hid, 1'b1, bad_ops[$urandom_range(0, 2)],
                         $urandom_range(0, 2), "rnd_unk", g);
        default: bus_txn(1'($urandom_range(0, 1)), d, a, 4'($urandom_range(0, 15)), hid, 1'b1,
                         amo_ops[$urandom_range(0, 8)], $urandom_range(0, 2), "rnd_amo", g);
      endcase
    end
    for (int w = 0; w < 8; w++) rd_word(32'(w) << 2, "final_rd", g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
# bus_mem_slave

Word-addressed memory responder terminating the shared hart bus driven by the 2x1 hart arbiter. It accepts one request at a time and answers each with a single-cycle acknowledge after a fixed latency. It performs plain byte-enabled reads and writes. It also executes RV32A atomics: LR/SC with per-hart reservations, and AMO read-modify-write. It sits between the arbiter output and on-chip RAM and serves as both the simulation memory model and the FPGA memory.

## Interface
- ADDR_WIDTH, 10: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 1: cycles from request capture to `o_ack`; legal range 1..15.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_bus_en  in  1  request valid; held by initiator until it sees `o_ack`.
- i_wr_en  in  1  1 = write, 0 = read (ignored when `i_atomic`=1).
- i_wr_data  in  32  store data / AMO operand.
- i_addr  in  32  byte address; word index = i_addr[ADDR_WIDTH+1:2]; other bits ignored.
- i_byte_en  in  4  byte lanes for plain writes.
- i_id  in  1  requesting hart (0/1).
- i_atomic  in  1  request is an RV32A operation; tied 0 when atomics are not built.
- i_operation  in  7  AMO funct7; funct5 = [6:2]; aq/rl = [1:0] are ignored.
- o_ack  out  1  one-cycle completion pulse.
- o_rd_data  out  32  response data; valid only while `o_ack`=1, else 0.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: when `i_bus_en`=1, capture addr, data, byte_en, id, atomic, op and wr_en, and issue the RAM read of the addressed word.
  - LATENCY=1: go to ACK.
  - LATENCY>1: go to WAIT with counter = LATENCY-1.
- WAIT: decrement the counter each cycle; go to ACK when it reaches 1.
- ACK: drive `o_ack`=1 and `o_rd_data`, commit any write, then go to IDLE unconditionally. `i_bus_en` is not sampled in ACK.
- Plain read: `o_rd_data` = full word; `i_byte_en` is ignored.
- Plain write: bytes with byte_en[k]=1 are written in the ACK cycle. `o_rd_data` = 0.
- Atomics are full-word operations; `i_byte_en` is ignored.
- LR (00010): return the word; set reservation[id] = {valid, word index}.
- SC (00011): succeeds iff reservation[id] is valid and its index matches.
  - Success: write `i_wr_data` and return 0.
  - Failure: no write; return 1.
  - reservation[id] is cleared in either case.
- AMO operations:
  - Ops: SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
  - Return the old word and write f(old, wr_data) in the ACK cycle.
  - MIN/MAX use signed compare; MINU/MAXU use unsigned compare.
  - ADD wraps modulo 2^32.
- Unknown funct5 with `i_atomic`=1: behaves as LR without setting a reservation, i.e. read only, no write.
- Reservation kill: any committed write (plain, successful SC, AMO) clears every valid reservation whose index equals the written word index, including the writer's own. This applies regardless of byte_en.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, `o_ack`=0, `o_rd_data`=0, counter 0, both reservations invalid.
- Request captured in IDLE at cycle T gives `o_ack`=1 at cycle T+LATENCY, for exactly one cycle.
- Back-to-back requests: minimum spacing from one ack to the next capture is 1 cycle; IDLE follows ACK.
- Throughput: one transaction per LATENCY+1 cycles.
- The initiator deasserts `i_bus_en` combinationally during the ack cycle. The block tolerates `i_bus_en` staying high through ACK with no duplicate capture.
- `i_bus_en` dropping before ack (protocol violation): the captured request still completes and acks.
- Write commit and reservation kill occur on the ACK-cycle rising edge. An LR to the same word in the next transaction sees the new data.
- Reset asserted mid-transaction: immediate return to IDLE, no ack, pending write dropped, reservations cleared.
- Address above depth aliases modulo 2^ADDR_WIDTH words.

## Test plan
- Reset, LATENCY=2: write 0xDEADBEEF to 0x10 with byte_en=4'hF, then read 0x10 -> each ack exactly 2 cycles after capture; read returns 0xDEADBEEF; write ack has rd_data=0.
- Byte enables: word 0x00000000, write 0xAABBCCDD with byte_en=4'b0101 -> read returns 0x00BB00DD.
- LR/SC: hart0 LR 0x20 then SC 0x20 data 5 -> SC returns 0 and word becomes 5. A second SC returns 1 and the word is unchanged.
- Reservation kill: hart0 LR 0x20; hart1 plain write 0x20 = 7; hart0 SC 0x20 = 9 -> returns 1; word stays 7.
- AMOs on word 0xFFFFFFFE:
  - AMOMAX operand 1 -> returns 0xFFFFFFFE; word becomes 1.
  - Then AMOMINU operand 0x80000000 -> returns 1; word stays 1.
  - Then AMOADD 0xFFFFFFFF -> word becomes 0.
- Reset mid-WAIT during write of 0x55 to 0x30, word previously 0x11 -> no ack; word still 0x11; `o_ack`/`o_rd_data` are 0 during reset.
